// File: rtl/quant_pkg.sv
// Shared types and constants for the quantised accumulator-to-ReLU sequencer.
// Holds the drain FSM state encoding and the capture mode values.
`timescale 1ns/1ps
package quant_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic MODE_BURST  = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/quant_ch_bank.sv
// N_CH x Pa holding bank for one captured channel set.
// Loads all channels in one cycle and presents the channel chosen by the read index.
`timescale 1ns/1ps
module quant_ch_bank
  import quant_pkg::*;
#(
  parameter int Pa    = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [N_CH*Pa-1:0]   i_data,
  input  logic [SEL_W-1:0]     i_rd_idx,
  output logic [Pa-1:0]        o_rd_data
);

  logic [Pa-1:0] r_bank [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        r_bank[k] <= '0;
      end
    end else if (i_load) begin
      for (int k = 0; k < N_CH; k++) begin
        r_bank[k] <= i_data[k*Pa +: Pa];
      end
    end
  end

  assign o_rd_data = r_bank[i_rd_idx];

endmodule

// File: rtl/quant_seq_mux.sv
// Captures a full accumulator channel set and drains it to ReLU over valid/ready,
// either every channel in order (burst) or one selected channel (single).
`timescale 1ns/1ps
module quant_seq_mux
  import quant_pkg::*;
#(
  parameter int Pa    = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*Pa-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [Pa-1:0]        out_data,
  output logic [SEL_W-1:0]     out_ch,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t           r_state;
  state_t           w_stateNext;
  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_cntNext;
  logic             r_mode;
  logic             w_modeNext;

  logic             w_capture;
  logic             w_xfer;
  logic [SEL_W:0]   w_selWide;
  logic [SEL_W-1:0] w_selClamp;

  // Widened compare keeps the clamp meaningful when N_CH is not a power of two.
  assign w_selWide  = {1'b0, sel};
  assign w_selClamp = (w_selWide >= (SEL_W+1)'(N_CH)) ? LAST_CH : sel;

  assign out_valid = (r_state == ST_DRAIN);
  assign busy      = (r_state == ST_DRAIN);
  assign out_ch    = r_cnt;
  assign out_last  = (r_state == ST_DRAIN) && (r_mode || (r_cnt == LAST_CH));
  assign w_xfer    = out_valid && out_ready;
  // Accepting on the last beat gives zero-bubble chaining of sets.
  assign in_ready  = (r_state == ST_IDLE) || (w_xfer && out_last);
  assign w_capture = in_valid && in_ready;

  quant_ch_bank #(
    .Pa    (Pa),
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_capture),
    .i_data    (in_data),
    .i_rd_idx  (r_cnt),
    .o_rd_data (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_BURST;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_mode  <= w_modeNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_modeNext  = r_mode;
    if (w_capture) begin
      w_stateNext = ST_DRAIN;
      w_modeNext  = mode;
      w_cntNext   = (mode == MODE_SINGLE) ? w_selClamp : '0;
    end else if (w_xfer && !out_last) begin
      w_cntNext   = r_cnt + SEL_W'(1);
    end else if (w_xfer) begin
      w_stateNext = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_quant_seq_mux.sv
// Self-checking bench for quant_seq_mux: vector table, scoreboard of expected beats,
// and directed sequences for back-pressure, back-to-back sets, reset and clamping.
`timescale 1ns/1ps
module tb_quant_seq_mux;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
    logic       last;
  } beat_t;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] data;
    int          expBeats;
    logic [7:0]  expFirst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inData = '0;
  logic        inValid = 1'b0;
  logic        inMode = 1'b0;
  logic [1:0]  inSel = '0;
  logic        outReady = 1'b1;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  logic [23:0] inData3 = '0;
  logic        inValid3 = 1'b0;
  logic        inMode3 = 1'b0;
  logic [1:0]  inSel3 = '0;
  logic        outReady3 = 1'b0;
  logic        in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_last3;
  logic        busy3;

  int          tests = 0;
  int          fails = 0;
  int          beatsSeen = 0;
  logic [7:0]  firstData = '0;
  beat_t       sb[$];
  vec_t        vecs[5];

  always #5 clk = ~clk;

  quant_seq_mux #(.Pa(8), .N_CH(4)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(in_ready),
    .mode(inMode), .sel(inSel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_last(out_last), .out_ready(outReady), .busy(busy)
  );

  quant_seq_mux #(.Pa(8), .N_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(inData3), .in_valid(inValid3), .in_ready(in_ready3),
    .mode(inMode3), .sel(inSel3), .out_data(out_data3), .out_ch(out_ch3),
    .out_valid(out_valid3), .out_last(out_last3), .out_ready(outReady3), .busy(busy3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected beats are queued at capture and retired on each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (inValid && in_ready) begin
        if (inMode) begin
          beat_t b;
          b.data = inData[inSel*8 +: 8];
          b.ch   = inSel;
          b.last = 1'b1;
          sb.push_back(b);
        end else begin
          for (int k = 0; k < 4; k++) begin
            beat_t b;
            b.data = inData[k*8 +: 8];
            b.ch   = 2'(k);
            b.last = (k == 3);
            sb.push_back(b);
          end
        end
      end
      if (out_valid && outReady) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpectedBeat: got data 0x%0h ch %0d, expected no beat", out_data, out_ch);
        end else begin
          beat_t e;
          e = sb.pop_front();
          checkOutput("beatData", {24'b0, out_data}, {24'b0, e.data});
          checkOutput("beatCh", {30'b0, out_ch}, {30'b0, e.ch});
          checkOutput("beatLast", {31'b0, out_last}, {31'b0, e.last});
        end
        if (beatsSeen == 0) firstData = out_data;
        beatsSeen++;
      end
    end
  end

  // Presents one set, waits for acceptance, then scrambles inputs to show they are ignored.
  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [31:0] d);
    bit ok = 0;
    @(posedge clk); #1;
    inValid = 1'b1; inData = d; inMode = m; inSel = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) checkOutput("captureTimeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0; inData = $urandom; inMode = ~m; inSel = ~s;
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) checkOutput("idleTimeout", 32'd0, 32'd1);
  endtask

  logic       patR [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] patD [6] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
  logic [1:0] patC [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{mode: 1'b0, sel: 2'd0, data: 32'h44332211, expBeats: 4, expFirst: 8'h11};
    vecs[1] = '{mode: 1'b1, sel: 2'd2, data: 32'h44332211, expBeats: 1, expFirst: 8'h33};
    vecs[2] = '{mode: 1'b1, sel: 2'd0, data: 32'hD4C3B2A1, expBeats: 1, expFirst: 8'hA1};
    vecs[3] = '{mode: 1'b0, sel: 2'd3, data: 32'hEFBEADDE, expBeats: 4, expFirst: 8'hDE};
    vecs[4] = '{mode: 1'b1, sel: 2'd3, data: 32'h89ABCDEF, expBeats: 1, expFirst: 8'h89};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstLast", {31'b0, out_last}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstData", {24'b0, out_data}, 32'd0);
    checkOutput("rstCh", {30'b0, out_ch}, 32'd0);
    checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      beatsSeen = 0;
      applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].data);
      checkOutput("firstLatencyValid", {31'b0, out_valid}, 32'd1);
      waitIdle();
      checkOutput("vecBeats", beatsSeen, vecs[i].expBeats);
      checkOutput("vecFirst", {24'b0, firstData}, {24'b0, vecs[i].expFirst});
    end

    // Back-pressure: the held beat must stay frozen while ready is low.
    applyStimulus(1'b0, 2'd0, 32'h44332211);
    for (int i = 0; i < 6; i++) begin
      outReady = patR[i];
      @(negedge clk);
      checkOutput("bpData", {24'b0, out_data}, {24'b0, patD[i]});
      checkOutput("bpCh", {30'b0, out_ch}, {30'b0, patC[i]});
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    waitIdle();

    // Back-to-back: second set waits on in_valid and lands on the last beat of the first.
    @(posedge clk); #1;
    inValid = 1'b1; inData = 32'h44332211; inMode = 1'b0; inSel = 2'd0;
    @(negedge clk);
    checkOutput("b2bReadyIdle", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    inData = 32'hD0C0B0A0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("b2bInReady", {31'b0, in_ready}, (c == 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("b2bValid", {31'b0, out_valid}, 32'd1);
    checkOutput("b2bData", {24'b0, out_data}, 32'hA0);
    checkOutput("b2bCh", {30'b0, out_ch}, 32'd0);
    waitIdle();

    // Reset mid-drain discards the set immediately.
    applyStimulus(1'b0, 2'd0, 32'h44332211);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", {31'b0, out_valid}, 32'd0);
    checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("postRstValid", {31'b0, out_valid}, 32'd0);
      checkOutput("postRstInReady", {31'b0, in_ready}, 32'd1);
    end

    // Three-channel instance: out-of-range sel clamps to the top channel.
    @(posedge clk); #1;
    inValid3 = 1'b1; inData3 = 24'h7C6B5A; inMode3 = 1'b1; inSel3 = 2'd3;
    @(posedge clk); #1;
    inValid3 = 1'b0; inSel3 = 2'd0;
    @(negedge clk);
    checkOutput("clampValid", {31'b0, out_valid3}, 32'd1);
    checkOutput("clampData", {24'b0, out_data3}, 32'h7C);
    checkOutput("clampCh", {30'b0, out_ch3}, 32'd2);
    checkOutput("clampLast", {31'b0, out_last3}, 32'd1);
    outReady3 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("clampDone", {31'b0, out_valid3}, 32'd0);

    checkOutput("sbEmpty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quant_seq_mux.md
Name: quant_seq_mux

Overview:
Parametrised successor to the 4:1 AC-output selector feeding ReLU. It captures one full set of N_CH accumulator-stage outputs in a single handshake and drains them to the ReLU stage over a valid/ready stream. Two drain modes:
- Burst mode sends every channel, lowest first.
- Single mode sends only the channel named by sel.
The block sits between the AC3 output bank and the ReLU unit, and it decouples ReLU back-pressure from the accumulators.

Parameters:
- Pa, 8, data width per channel in bits.
- N_CH, 4, number of input channels; must be 2 or more.
- SEL_W, $clog2(N_CH), width of the channel index.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_CH*Pa  packed channel outputs; channel k occupies bits [k*Pa +: Pa].
- in_valid  in  1  producer presents a complete channel set.
- in_ready  out  1  block accepts a set this cycle.
- mode  in  1  0 = burst (all channels), 1 = single (channel sel only); sampled at capture.
- sel  in  SEL_W  channel for single mode; sampled at capture.
- out_data  out  Pa  current channel value to ReLU.
- out_ch  out  SEL_W  index of the channel currently on out_data.
- out_valid  out  1  out_data/out_ch are valid.
- out_last  out  1  current beat is the final beat of the set.
- out_ready  in  1  ReLU accepts the beat.
- busy  out  1  block holds an undrained set.

Behaviour:
- Two states, IDLE and DRAIN. Reset forces IDLE immediately and asynchronously.
- Reset values: out_valid=0, out_last=0, busy=0, out_data=0, out_ch=0, bank registers=0, in_ready=1 once in IDLE.
- Capture:
  - In IDLE, in_ready=1. On in_valid && in_ready, latch all N_CH channels into the bank.
  - Latch mode_r=mode. Set cnt = (mode ? sel_c : 0), where sel_c = sel clamped to N_CH-1 when sel >= N_CH (non-power-of-two N_CH).
  - Go to DRAIN.
- Latency: out_valid rises on the cycle after capture, so capture-to-first-beat is 1 clock.
- DRAIN:
  - out_valid=1, out_data=bank[cnt], out_ch=cnt, busy=1.
  - out_last = mode_r || (cnt == N_CH-1).
- Beat transfer happens on out_valid && out_ready:
  - Not last: cnt increments by 1; out_data changes the next cycle.
  - Last: return to IDLE, out_valid=0 the next cycle.
- Stall: while out_ready=0, out_data, out_ch and out_last hold stable. Must not change while valid && !ready.
- Back-to-back sets:
  - in_ready is also 1 in DRAIN on the cycle the last beat transfers, i.e. in_ready = IDLE || (out_valid && out_ready && out_last).
  - A set captured then goes straight to DRAIN with the new cnt, giving zero bubble between sets.
  - This combinational out_ready→in_ready path is deliberate.
- in_data changing while in DRAIN has no effect on the bank. mode/sel changing after capture has no effect.
- in_valid in DRAIN without a last-beat transfer: not accepted; the producer must hold in_valid.
- Reset mid-DRAIN: the set is discarded, no further beats are issued, and out_valid drops asynchronously.
- Width rules:
  - No arithmetic on data; values pass bit-exact.
  - cnt is SEL_W bits and never exceeds N_CH-1; no wrap in burst mode because the last beat exits.
- Throughput: burst mode 1 set per N_CH cycles; single mode 1 set per cycle when out_ready is held at 1.

Decomposition:
- Shared package quant_pkg: state enum (ST_IDLE, ST_DRAIN), mode constants (MODE_BURST=1'b0, MODE_SINGLE=1'b1).
- Sub-module quant_ch_bank: N_CH x Pa register bank with load enable, async reset and a read index. The FSM and handshake logic stay in quant_seq_mux.

Test Plan:
- Reset mid-operation: capture a burst set, take 1 beat, assert rst → out_valid=0 and busy=0 in the same cycle; after release, in_ready=1 and no further beats appear.
- Burst drain, Pa=8, N_CH=4: in_data channels {0x11,0x22,0x33,0x44}, mode=0, out_ready=1 → beats 0x11,0x22,0x33,0x44 on cycles 1-4 after capture; out_ch 0..3; out_last only on 0x44.
- Single mode with clamp: mode=1, sel=2 → one beat 0x33, out_ch=2, out_last=1, back to IDLE. With N_CH=3 and sel=3 → one beat carrying channel 2.
- Back-pressure: burst set, out_ready toggles 1,0,0,1,1,1 → beats 0x11 then 0x22 held for 3 cycles unchanged, then 0x33, 0x44; no beat lost or duplicated.
- Back-to-back: second set {0xA0,0xB0,0xC0,0xD0} with in_valid held during the first drain → captured on the cycle 0x44 transfers; 0xA0 is on out_data the next cycle with no idle gap.
